uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Asynchronous serial receiver for 8N1 UART frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It oversamples the incoming line with the system clock, samples each bit at its midpoint, and presents the received byte with a one-cycle completion strobe. It sits between the board RX pin and any byte-oriented consumer such as a FIFO or a command parser.

## Interface
Parameters:
- BAUD_RATE, 115200 — line bit rate in bits/s.
- CLK_HZ, 25000000 — i_Clk frequency in Hz.
- CLKS_PER_BIT (derived localparam) — CLK_HZ/BAUD_RATE, integer division; 217 at defaults.
- HALF_BIT (derived localparam) — (CLKS_PER_BIT-1)/2; 108 at defaults.

Ports:
- i_Clk — in, 1 — system clock, rising edge. The block has one clock.
- i_reset — in, 1 — synchronous, active-low reset.
- i_serial — in, 1 — asynchronous RX line; idles high.
- o_rx_data — out, 8 — last correctly framed byte.
- o_rx_done — out, 1 — one-cycle strobe marking a new o_rx_data value.

## Operation
- i_serial passes through a 2-flop synchronizer; the FSM uses only the synchronized value (rx_s).
- FSM states:
  - IDLE: bit counter = 0 and clock counter = 0. rx_s = 0 → START.
  - START: counts HALF_BIT cycles, then checks rx_s.
    - rx_s = 0 → DATA, with the clock counter cleared.
    - rx_s = 1 → the low pulse is treated as a glitch → IDLE.
  - DATA: every CLKS_PER_BIT cycles, samples rx_s into shift bit [bit_idx], LSB first. After bit 7 → STOP.
  - STOP: samples rx_s CLKS_PER_BIT cycles after bit 7.
    - rx_s = 1 → load o_rx_data from the shift register, go to DONE.
    - rx_s = 0 → framing error: discard the byte, no strobe, go to WAIT_IDLE.
  - DONE: o_rx_done = 1 for this cycle only → IDLE.
  - WAIT_IDLE: stays until rx_s = 1 → IDLE. This prevents a break condition from being read as a new start bit.
- o_rx_data changes only on a good frame. It holds its value otherwise, including across glitches and framing errors.
- Back-to-back frames are supported. The FSM is back in IDLE before the stop bit ends, so the next start edge is caught.
- Counter widths are sized as $clog2(CLKS_PER_BIT) bits for the clock counter and 3 bits for the bit index. Counters never wrap mid-bit; the terminal count resets them to 0.
- i_reset = 0 at any clock edge, including mid-frame, forces the following:
  - state = IDLE
  - all counters = 0
  - shift register = 0
  - o_rx_data = 8'h00
  - o_rx_done = 0
  - synchronizer flops = 1
- The partial frame is discarded. After reset deasserts, reception starts at the next falling edge.

## Timing
- Reset values: o_rx_data = 8'h00, o_rx_done = 0.
- Let E be the first rising edge at which i_serial is sampled low at the start bit.
  - Synchronizer: rx_s is low at edge E+1; the FSM enters START at E+2.
  - Start check: edge E+2+HALF_BIT.
  - Data bit k (k = 0..7): edge E+2+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - Stop sample: edge E+2+HALF_BIT+9·CLKS_PER_BIT. At defaults this is E+2063.
  - o_rx_done is high during the cycle after the stop sample, for exactly 1 cycle. At defaults this is edge E+2064.
  - o_rx_data takes the new byte at the same edge o_rx_done rises and holds afterwards.
- Tolerance: with mid-bit sampling, a sender baud error of up to ±2% must decode correctly.
- A low pulse shorter than HALF_BIT cycles after synchronization produces no strobe. The FSM returns to IDLE at most HALF_BIT+3 cycles after the pulse starts.

## Test plan
- Reset: hold i_reset = 0 for 10 cycles with i_serial = 1. Required: o_rx_data = 8'h00 and o_rx_done = 0 throughout.
- Single byte: release reset, wait 10 cycles, send 8'b10110010 at 217 clocks/bit. Required: one o_rx_done pulse exactly 1 cycle wide, about 2064 cycles after the start edge; o_rx_data = 8'hB2 and held afterwards.
- Second byte: wait 2 bit times, then send 8'b10001000. Required: one pulse; o_rx_data = 8'h88. Back-to-back 8'h00 then 8'hFF with no idle gap: two pulses, correct values in order.
- Glitch: drive i_serial low for 50 cycles, then high. Required: no o_rx_done, o_rx_data unchanged. A following frame 8'h5A decodes correctly.
- Framing error: send 8'hC3 with the stop bit held low for 2 bit times, then high. Required: no pulse, o_rx_data keeps its prior value. A following 8'h55 decodes correctly.
- Reset mid-frame: assert i_reset = 0 during data bit 4 of 8'hA5. Required: outputs go to reset values at the next edge and no pulse occurs for that frame. A following 8'h3C decodes correctly.

Source files
------------

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered
// byte output with a one-cycle completion strobe.
`timescale 1ns/1ps

module uart_rx_unit #(
   parameter int BAUD_RATE = 115200,
   parameter int CLK_HZ    = 25000000
) (
   input  logic       i_Clk,
   input  logic       i_reset,
   input  logic       i_serial,
   output logic [7:0] o_rx_data,
   output logic       o_rx_done
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
   localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE,
      WAIT_IDLE
   } state_t;

   logic             sync_1;
   logic             rx_s;

   state_t           state,   state_n;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift,   shift_n;
   logic [7:0]       data_r,  data_n;
   logic             done_r,  done_n;

   // Synchronizer resets to the idle-high line level so reset never looks like a start edge.
   always_ff @(posedge i_Clk) begin
      if (!i_reset) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= i_serial;
         rx_s   <= sync_1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_reset) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         data_r  <= '0;
         done_r  <= 1'b0;
      end else begin
         state   <= state_n;
         clk_cnt <= clk_cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         data_r  <= data_n;
         done_r  <= done_n;
      end
   end

   // Every counter hits a terminal count and returns to zero; nothing wraps mid-bit.
   always_comb begin
      state_n   = state;
      clk_cnt_n = clk_cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      data_n    = data_r;
      done_n    = 1'b0;

      unique case (state)
         IDLE: begin
            clk_cnt_n = '0;
            bit_idx_n = '0;
            if (!rx_s) begin
               state_n = START;
            end
         end

         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_n        = '0;
               shift_n[bit_idx] = rx_s;
               if (bit_idx == 3'd7) begin
                  bit_idx_n = '0;
                  state_n   = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_n = '0;
               state_n   = rx_s ? DONE : WAIT_IDLE;
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end

         DONE: begin
            data_n  = shift;
            done_n  = 1'b1;
            state_n = IDLE;
         end

         WAIT_IDLE: begin
            clk_cnt_n = '0;
            bit_idx_n = '0;
            if (rx_s) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign o_rx_data = data_r;
   assign o_rx_done = done_r;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: queue-based expected-strobe model checked
// every cycle, directed frames plus randomized frames, glitches and framing errors.
`timescale 1ns/1ps

module tb_uart_rx_unit;

   localparam int CPB      = 25000000 / 115200;
   localparam int HALF     = (CPB - 1) / 2;
   localparam int DONE_LAT = 2 + HALF + 9 * CPB + 1;

   typedef struct {
      int         due;
      logic [7:0] b;
   } exp_t;

   logic       i_Clk = 1'b0;
   logic       i_reset;
   logic       i_serial;
   logic [7:0] o_rx_data;
   logic       o_rx_done;

   int         checks        = 0;
   int         failures      = 0;
   int         cyc           = 0;
   int         done_seen     = 0;
   int         last_done_cyc = -1;
   logic [7:0] model_data    = 8'h00;
   exp_t       exp_q[$];

   uart_rx_unit #(
      .BAUD_RATE(115200),
      .CLK_HZ   (25000000)
   ) dut (
      .i_Clk    (i_Clk),
      .i_reset  (i_reset),
      .i_serial (i_serial),
      .o_rx_data(o_rx_data),
      .o_rx_done(o_rx_done)
   );

   always #20 i_Clk = ~i_Clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Expected behaviour: a good frame whose start edge is E yields exactly one strobe,
   // carrying that byte, DONE_LAT cycles later; the data output holds between strobes.
   initial begin : compare_proc
      logic rst_seen;
      logic exp_done;
      forever begin
         @(posedge i_Clk);
         cyc++;
         rst_seen = i_reset;
         #1;
         exp_done = 1'b0;
         if (rst_seen !== 1'b1) begin
            model_data = 8'h00;
            exp_q.delete();
         end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_done   = 1'b1;
            model_data = exp_q[0].b;
            void'(exp_q.pop_front());
         end
         if (o_rx_done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
         end
         check_output("rx_done", {31'd0, o_rx_done}, {31'd0, exp_done});
         check_output("rx_data", {24'd0, o_rx_data}, {24'd0, model_data});
      end
   end

   task automatic idle(input int n);
      i_serial = 1'b1;
      repeat (n) @(negedge i_Clk);
   endtask

   // Called on a negedge; returns the start edge index it produced.
   task automatic apply_stimulus(input logic [7:0] b, input int cps, input int stop_low_bits,
                                 input bit expect_ok, output int e);
      e        = cyc + 1;
      i_serial = 1'b0;
      if (expect_ok) exp_q.push_back('{due: e + DONE_LAT, b: b});
      repeat (cps) @(negedge i_Clk);
      for (int i = 0; i < 8; i++) begin
         i_serial = b[i];
         repeat (cps) @(negedge i_Clk);
      end
      if (stop_low_bits > 0) begin
         i_serial = 1'b0;
         repeat (stop_low_bits * cps) @(negedge i_Clk);
      end
      i_serial = 1'b1;
      repeat (cps) @(negedge i_Clk);
   endtask

   task automatic glitch(input int len);
      i_serial = 1'b0;
      repeat (len) @(negedge i_Clk);
      i_serial = 1'b1;
   endtask

   initial begin : main_proc
      int         e;
      logic [7:0] rb;
      int         rcps;
      logic [7:0] pat;

      i_reset  = 1'b0;
      i_serial = 1'b1;
      @(negedge i_Clk);
      repeat (10) @(negedge i_Clk);
      check_output("reset_data", {24'd0, o_rx_data}, 32'h00);
      check_output("reset_done", {31'd0, o_rx_done}, 32'h0);
      i_reset = 1'b1;
      idle(10);

      apply_stimulus(8'b10110010, CPB, 0, 1'b1, e);
      check_output("b2_latency", last_done_cyc, e + 2064);
      check_output("b2_data", {24'd0, o_rx_data}, 32'hB2);
      check_output("b2_pulses", done_seen, 1);

      idle(2 * CPB);
      apply_stimulus(8'b10001000, CPB, 0, 1'b1, e);
      check_output("88_data", {24'd0, o_rx_data}, 32'h88);
      check_output("88_pulses", done_seen, 2);

      apply_stimulus(8'h00, CPB, 0, 1'b1, e);
      apply_stimulus(8'hFF, CPB, 0, 1'b1, e);
      check_output("b2b_data", {24'd0, o_rx_data}, 32'hFF);
      check_output("b2b_pulses", done_seen, 4);

      glitch(50);
      idle(300);
      check_output("glitch_data", {24'd0, o_rx_data}, 32'hFF);
      check_output("glitch_pulses", done_seen, 4);
      apply_stimulus(8'h5A, CPB, 0, 1'b1, e);
      check_output("5a_data", {24'd0, o_rx_data}, 32'h5A);

      apply_stimulus(8'hC3, CPB, 2, 1'b0, e);
      idle(CPB);
      check_output("frame_err_data", {24'd0, o_rx_data}, 32'h5A);
      check_output("frame_err_pulses", done_seen, 5);
      apply_stimulus(8'h55, CPB, 0, 1'b1, e);
      check_output("55_data", {24'd0, o_rx_data}, 32'h55);

      // Abort 8'hA5 partway through data bit 4 with a reset.
      pat      = 8'hA5;
      i_serial = 1'b0;
      repeat (CPB) @(negedge i_Clk);
      for (int i = 0; i < 4; i++) begin
         i_serial = pat[i];
         repeat (CPB) @(negedge i_Clk);
      end
      i_serial = pat[4];
      repeat (100) @(negedge i_Clk);
      i_reset  = 1'b0;
      i_serial = 1'b1;
      @(posedge i_Clk);
      #1;
      check_output("midreset_data", {24'd0, o_rx_data}, 32'h00);
      check_output("midreset_done", {31'd0, o_rx_done}, 32'h0);
      @(negedge i_Clk);
      repeat (3) @(negedge i_Clk);
      i_reset = 1'b1;
      idle(2 * CPB);
      check_output("midreset_pulses", done_seen, 6);
      apply_stimulus(8'h3C, CPB, 0, 1'b1, e);
      check_output("3c_data", {24'd0, o_rx_data}, 32'h3C);
      check_output("3c_pulses", done_seen, 7);

      // Random frames with sender baud error within +-2%, glitches and framing errors.
      for (int n = 0; n < 16; n++) begin
         rb   = 8'($urandom_range(0, 255));
         rcps = int'($urandom_range(CPB - 4, CPB + 4));
         if ($urandom_range(0, 3) == 0) begin
            glitch(int'($urandom_range(5, 90)));
            idle(int'($urandom_range(150, 300)));
         end
         if ($urandom_range(0, 5) == 0) begin
            apply_stimulus(rb, rcps, int'($urandom_range(1, 2)), 1'b0, e);
         end else begin
            apply_stimulus(rb, rcps, 0, 1'b1, e);
         end
         idle(int'($urandom_range(0, 400)));
      end

      idle(CPB);
      check_output("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
